// File: rtl/zed64_vid_pkg.sv
// Shared video-fetch types and constants for the zed64 character display path.
package zed64_vid_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CELL_W = 8;

  localparam logic [ADDR_W-1:0] DEF_SCREEN_BASE = 16'h0100;
  localparam logic [ADDR_W-1:0] DEF_FONT_BASE   = 16'h0800;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CODE,
    ST_WT_CODE,
    ST_RD_FONT,
    ST_WT_FONT,
    ST_HOLD
  } fetch_state_e;

  // Screen-code address of a cell, wrapping at the chip-RAM address width.
  function automatic logic [ADDR_W-1:0] code_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] row,
                                                  input logic [ADDR_W-1:0] col,
                                                  input logic [ADDR_W-1:0] cols);
    return base + row * cols + col;
  endfunction

  // Font-byte address of one glyph line, wrapping at the chip-RAM address width.
  function automatic logic [ADDR_W-1:0] font_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] code,
                                                  input logic [ADDR_W-1:0] glyph_h,
                                                  input logic [ADDR_W-1:0] gline);
    return base + code * glyph_h + gline;
  endfunction

endpackage

// File: rtl/glyph_shifter.sv
// Glyph row shifter with a one-deep holding register filled by the fetch FSM.
module glyph_shifter
  import zed64_vid_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [CELL_W-1:0] wr_data_i,
  input  logic              load_i,
  input  logic              take_i,
  input  logic              shift_i,
  output logic              hold_valid_o,
  output logic              pix_c_o
);

  logic [CELL_W-1:0] shift_q, shift_d;
  logic [CELL_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic [CELL_W-1:0] load_val_c;

  // Next shifter/holding state; a load also supplies the pixel of its own cycle.
  always_comb begin
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    load_val_c   = take_i ? hold_q : '0;
    pix_c_o      = shift_q[CELL_W-1];
    if (load_i) begin
      pix_c_o = load_val_c[CELL_W-1];
      shift_d = shift_i ? {load_val_c[CELL_W-2:0], 1'b0} : load_val_c;
      if (take_i) hold_valid_d = 1'b0;
    end else if (shift_i) begin
      shift_d = {shift_q[CELL_W-2:0], 1'b0};
    end
    if (wr_i) begin
      hold_d       = wr_data_i;
      hold_valid_d = 1'b1;
    end
    if (clr_i) hold_valid_d = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/text_glyph_fetch.sv
// Character-mode fetch: reads screen codes and font bytes, serialises glyph rows.
module text_glyph_fetch
  import zed64_vid_pkg::*;
#(
  parameter int unsigned       COLS        = 40,
  parameter int unsigned       ROWS        = 25,
  parameter logic [ADDR_W-1:0] SCREEN_BASE = DEF_SCREEN_BASE,
  parameter logic [ADDR_W-1:0] FONT_BASE   = DEF_FONT_BASE,
  parameter int unsigned       GLYPH_H     = 8
) (
  input  logic              pixclk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              hactive,
  input  logic              vactive,
  input  logic              line_start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              pix_out,
  output logic              pix_valid,
  output logic              underrun
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned CNT_W = $clog2(COLS + 1);
  localparam int unsigned ROW_W = $clog2(ROWS + 1);
  localparam int unsigned GL_W  = $clog2(GLYPH_H);
  localparam int unsigned PH_W  = $clog2(CELL_W);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CELL_W - 1);

  fetch_state_e      state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  cells_q, cells_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [GL_W-1:0]   gline_q, gline_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic              hact_q;
  logic              armed_q, armed_d;
  logic              frame_ok_q, frame_ok_d;
  logic              underrun_q, underrun_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              pix_out_q, pix_out_d;
  logic              pix_valid_q, pix_valid_d;

  logic hold_valid_c, pix_c;
  logic hact_fall_c, load_c, line_ok_c, cell_left_c, take_c, starve_c;
  logic hold_wr_c, hold_clr_c;

  // Phase idles at its last value so the first active cycle is always a load.
  assign hact_fall_c = hact_q & ~hactive;
  assign load_c      = hactive & (phase_q == PH_LAST);
  assign line_ok_c   = line_start & ~hactive & vactive & (frame_ok_q | frame_start) &
                       (frame_start | (row_q < ROW_W'(ROWS)));
  assign cell_left_c = armed_q & (cells_q < CNT_W'(COLS));
  assign take_c      = load_c & cell_left_c & hold_valid_c;
  assign starve_c    = load_c & cell_left_c & ~hold_valid_c;

  // Fetch FSM, raster counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cells_d     = cells_q;
    row_d       = row_q;
    gline_d     = gline_q;
    code_d      = code_q;
    armed_d     = armed_q;
    frame_ok_d  = frame_ok_q;
    underrun_d  = underrun_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    hold_wr_c   = 1'b0;
    hold_clr_c  = 1'b0;
    phase_d     = hactive ? phase_q + PH_W'(1) : PH_LAST;

    unique case (state_q)
      ST_IDLE: begin
        if (load_c && cell_left_c && (col_q < COL_W'(COLS - 1))) begin
          col_d   = col_q + COL_W'(1);
          state_d = ST_RD_CODE;
        end
      end
      ST_RD_CODE: state_d = ST_WT_CODE;
      ST_WT_CODE: begin
        code_d  = mem_data;
        state_d = ST_RD_FONT;
      end
      ST_RD_FONT: state_d = ST_WT_FONT;
      ST_WT_FONT: begin
        hold_wr_c = 1'b1;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (take_c) begin
          if (col_q < COL_W'(COLS - 1)) begin
            col_d   = col_q + COL_W'(1);
            state_d = ST_RD_CODE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_c && cell_left_c) cells_d = cells_q + CNT_W'(1);
    if (hact_fall_c) armed_d = 1'b0;

    if (frame_start) begin
      row_d      = '0;
      gline_d    = '0;
      col_d      = '0;
      underrun_d = 1'b0;
      frame_ok_d = 1'b1;
      armed_d    = 1'b0;
    end else if (hact_fall_c && vactive) begin
      gline_d = gline_q + GL_W'(1);
      if ((gline_q == GL_W'(GLYPH_H - 1)) && (row_q < ROW_W'(ROWS))) row_d = row_q + ROW_W'(1);
    end

    if (starve_c || (line_start && hactive)) underrun_d = 1'b1;

    // An accepted line start always restarts the prefetch at column 0.
    if (line_ok_c) begin
      state_d    = ST_RD_CODE;
      col_d      = '0;
      cells_d    = '0;
      armed_d    = 1'b1;
      hold_clr_c = 1'b1;
    end

    if (state_d == ST_RD_CODE) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = code_addr(SCREEN_BASE, ADDR_W'(row_d), ADDR_W'(col_d), ADDR_W'(COLS));
    end else if (state_d == ST_RD_FONT) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = font_addr(FONT_BASE, ADDR_W'(code_d), ADDR_W'(GLYPH_H), ADDR_W'(gline_d));
    end

    pix_valid_d = hactive & vactive & frame_ok_q & (row_q < ROW_W'(ROWS));
    pix_out_d   = pix_valid_d & pix_c;
  end

  // State registers.
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      cells_q     <= '0;
      row_q       <= '0;
      gline_q     <= '0;
      phase_q     <= PH_LAST;
      code_q      <= '0;
      hact_q      <= 1'b0;
      armed_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      underrun_q  <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      pix_out_q   <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cells_q     <= cells_d;
      row_q       <= row_d;
      gline_q     <= gline_d;
      phase_q     <= phase_d;
      code_q      <= code_d;
      hact_q      <= hactive;
      armed_q     <= armed_d;
      frame_ok_q  <= frame_ok_d;
      underrun_q  <= underrun_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  glyph_shifter u_shifter (
    .clk_i        (pixclk),
    .rst_i        (reset),
    .clr_i        (hold_clr_c),
    .wr_i         (hold_wr_c),
    .wr_data_i    (mem_data),
    .load_i       (load_c),
    .take_i       (take_c),
    .shift_i      (hactive),
    .hold_valid_o (hold_valid_c),
    .pix_c_o      (pix_c)
  );

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign pix_out   = pix_out_q;
  assign pix_valid = pix_valid_q;
  assign underrun  = underrun_q;

endmodule

// File: doc/text_glyph_fetch.md
Name: text_glyph_fetch

Overview:
- Character-mode video fetch stage sitting directly upstream of the VGA pixel output, in the pixel-clock domain.
- Reads screen codes and font bytes from the chip-RAM read port.
- Serialises 8-pixel glyph rows, one bit per pixel, aligned to the timing generator's active-display window.
- Feeds the palette/RGB stage that drives vgaR/G/B.

Parameters:
COLS, 40, character columns per row
ROWS, 25, character rows per frame
SCREEN_BASE, 16'h0100, chip-RAM address of screen code (row 0, col 0)
FONT_BASE, 16'h0800, chip-RAM address of glyph 0 row 0
GLYPH_H, 8, pixel lines per character row (power of two)

Ports:
pixclk  in  1  pixel clock, sole clock
reset  in  1  asynchronous, active-high
frame_start  in  1  one-cycle pulse in vblank, before the first visible line
hactive  in  1  horizontal active-display window
vactive  in  1  vertical active-display window
line_start  in  1  one-cycle pulse in hblank, at least 6 cycles before hactive rises
mem_rd  out  1  read strobe to chip RAM
mem_addr  out  16  read address
mem_data  in  8  read data, valid the cycle after mem_rd
pix_out  out  1  glyph pixel, 1 = foreground
pix_valid  out  1  pix_out is a displayed pixel
underrun  out  1  sticky: a glyph was not ready at shifter load

Behaviour:
- Reset is asynchronous and active-high. It forces all outputs to 0, FSM to IDLE, and clears counters, shifter, holding reg and holding_valid.
- Reset mid-line: output stays blank until the next frame_start.
- Counters:
  - col 0..COLS-1
  - gline 0..GLYPH_H-1
  - row 0..ROWS-1
  - phase 0..7 (pixel within cell)
- frame_start clears row, gline, col and underrun.
- Falling edge of hactive while vactive:
  - gline increments.
  - On wrap GLYPH_H-1 -> 0, row increments.
  - Past ROWS-1, row saturates and all output is blank until frame_start.
- Addresses, computed modulo 2^16:
  - code address = SCREEN_BASE + row*COLS + col
  - font address = FONT_BASE + {code,3'b0} + gline
- FSM states: IDLE, RD_CODE, WT_CODE, RD_FONT, WT_FONT, HOLD.
  - IDLE -> RD_CODE on line_start while vactive: prefetch col 0. Also on a shifter load while more columns remain.
  - RD_CODE: mem_rd=1, mem_addr=code address -> WT_CODE.
  - WT_CODE: latch mem_data as code -> RD_FONT.
  - RD_FONT: mem_rd=1, mem_addr=font address -> WT_FONT.
  - WT_FONT: mem_data -> holding; holding_valid=1 -> HOLD.
  - HOLD: wait for shifter load, then col++. Next state is RD_CODE if col < COLS-1, else IDLE.
- One fetch takes 4 cycles, which is under the 8-cycle cell, so there is no steady-state underrun.
- mem_rd is 0 in all other states.
- Shifter load happens on the first hactive cycle and on every phase==7 cycle.
  - If holding_valid: shifter <= holding, holding_valid <= 0.
  - Otherwise: shifter <= 0 and underrun <= 1.
  - Once COLS cells are consumed, further loads are 0 and do not set underrun.
- Shifter shifts left once per hactive cycle.
- Output is registered with 1-cycle latency:
  - pix_valid(t+1) = hactive(t) & vactive(t) & row<ROWS
  - pix_out(t+1) = current shifter MSB (bit7 first), else 0
- line_start coinciding with hactive: ignored, and underrun set.
- frame_start and line_start in the same cycle: frame_start is applied first, then the prefetch starts.

Decomposition:
- Package zed64_vid_pkg holds:
  - fetch FSM state enum
  - CELL_W=8
  - default SCREEN_BASE/FONT_BASE
  - address-width constant shared with the chip-RAM arbiter
- One natural sub-module: glyph_shifter (8-bit load/shift register plus holding reg and valid flag).

Test Plan:
- Reset held 3 cycles, then released: mem_rd, pix_out, pix_valid and underrun are all 0. FSM is IDLE with no reads.
- Set mem[0x0100]=23 and mem[0x0800+23*8+0]=8'hA5, then frame_start, line_start and hactive -> mem_rd at 0x0100 then 0x08B8. The first 8 valid pixels are 1,0,1,0,0,1,0,1.
- Run a full 320-pixel line with distinct codes per column -> exactly 40 code reads, in order 0x0100..0x0127. underrun stays 0.
- Run 8 lines -> gline wraps. The 9th line reads from 0x0128 (row 1) with font offset gline=0.
- Pulse line_start 2 cycles before hactive rises -> the first cell is 8 zero pixels and underrun=1. It stays set until frame_start.
- Assert reset at pixel 100 of a line -> outputs go 0 immediately. The next frame renders row 0 correctly.
